// File: rtl/mips_instr_encoder.sv
// Encodes symbolic MIPS instruction requests into 32-bit machine words.
// Words are queued in a small FIFO and streamed out with sequential word addresses.
module mips_instr_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [3:0]               req_op,
  input  logic [4:0]               req_rs,
  input  logic [4:0]               req_rt,
  input  logic [4:0]               req_rd,
  input  logic [25:0]              req_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [ADDR_W-1:0]        out_addr,
  output logic                     err_illegal,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  typedef enum logic [3:0] {
    OpAddu  = 4'd0,
    OpSubu  = 4'd1,
    OpSlt   = 4'd2,
    OpJr    = 4'd3,
    OpAddi  = 4'd4,
    OpAddiu = 4'd5,
    OpOri   = 4'd6,
    OpLw    = 4'd7,
    OpSw    = 4'd8,
    OpBeq   = 4'd9,
    OpLui   = 4'd10,
    OpJ     = 4'd11,
    OpJal   = 4'd12
  } op_e;

  logic [31:0]       mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]   level_q, level_d;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic [15:0] imm16;
  logic        accept, push, pop;

  assign imm16 = req_imm[15:0];

  // Fields not used by an op are never routed into the word, so they read as zero.
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (op_e'(req_op))
      OpAddu:  enc_word = {6'h00, req_rs, req_rt, req_rd, 5'd0, 6'h21};
      OpSubu:  enc_word = {6'h00, req_rs, req_rt, req_rd, 5'd0, 6'h23};
      OpSlt:   enc_word = {6'h00, req_rs, req_rt, req_rd, 5'd0, 6'h2A};
      OpJr:    enc_word = {6'h00, req_rs, 15'd0, 6'h08};
      OpAddi:  enc_word = {6'h08, req_rs, req_rt, imm16};
      OpAddiu: enc_word = {6'h09, req_rs, req_rt, imm16};
      OpOri:   enc_word = {6'h0D, req_rs, req_rt, imm16};
      OpLw:    enc_word = {6'h23, req_rs, req_rt, imm16};
      OpSw:    enc_word = {6'h2B, req_rs, req_rt, imm16};
      OpBeq:   enc_word = {6'h04, req_rs, req_rt, imm16};
      OpLui:   enc_word = {6'h0F, 5'd0, req_rt, imm16};
      OpJ:     enc_word = {6'h02, req_imm};
      OpJal:   enc_word = {6'h03, req_imm};
      default: enc_legal = 1'b0;
    endcase
  end

  assign req_ready   = (level_q != LvlW'(DEPTH));
  assign out_valid   = (level_q != '0);
  assign out_data    = mem_q[rd_ptr_q];
  assign out_addr    = addr_q;
  assign err_illegal = err_q;
  assign level       = level_q;

  // clr overrides any concurrent handshake on either side.
  assign accept = req_valid & req_ready & ~clr;
  assign push   = accept & enc_legal;
  assign pop    = out_valid & out_ready & ~clr;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      addr_q   <= ADDR_W'(BASE_ADDR);
      err_q    <= 1'b0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      addr_q   <= ADDR_W'(BASE_ADDR);
      err_q    <= 1'b0;
    end else begin
      level_q <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
        addr_q   <= addr_q + ADDR_W'(1);
      end
      if (accept && !enc_legal) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= enc_word;
  end

endmodule
